// File: rtl/wb_stage_if.sv
// Writeback-stage bus: memory-stage instruction handshake, data-memory load
// response and the register-file write port, grouped for the wb_stage ports.
interface wb_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  wb_sel;
    logic        reg_we;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [63:0] instret;

    // Upstream side: memory stage plus data-memory response, observing the write port.
    modport master (
        output in_valid, wb_sel, reg_we, rd, funct3, alu_result, pc_plus4,
        output dmem_rvalid, dmem_rdata,
        input  in_ready, rf_we, rf_waddr, rf_wdata, instret
    );

    // The writeback stage itself.
    modport slave (
        input  in_valid, wb_sel, reg_we, rd, funct3, alu_result, pc_plus4,
        input  dmem_rvalid, dmem_rdata,
        output in_ready, rf_we, rf_waddr, rf_wdata, instret
    );
endinterface

// File: rtl/wb_stage.sv
// rv32 writeback stage: selects load data / ALU result / PC+4 and drives a
// registered register-file write port. Define WB_INSTRET_EN to build the 64-bit instret counter.
module wb_stage (
    input  logic       clk,
    input  logic       rst,
    wb_stage_if.slave  bus
);

    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_ALU  = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;
    localparam logic [1:0] SEL_RSVD = 2'b11;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  sel_reg, sel_next;
    logic        we_reg, we_next;
    logic [4:0]  rd_reg, rd_next;
    logic [2:0]  funct3_reg, funct3_next;
    logic [1:0]  off_reg, off_next;
    logic        rf_we_reg, rf_we_next;
    logic [4:0]  rf_waddr_reg, rf_waddr_next;
    logic [31:0] rf_wdata_reg, rf_wdata_next;

    logic        accept;
    logic        load_accept;
    logic        load_done;
    logic [31:0] nonload_data;
    logic [31:0] load_data;
    logic [7:0]  rdata_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // A write only reaches the register file for real destinations with a defined source.
    function automatic logic write_gate(input logic we, input logic [4:0] r, input logic [1:0] s);
        return we && (r != 5'd0) && (s != SEL_RSVD);
    endfunction

    assign bus.in_ready = (state_reg == IDLE);
    assign accept       = bus.in_valid && (state_reg == IDLE);
    assign load_accept  = accept && (bus.wb_sel == SEL_LOAD) && bus.reg_we;
    assign load_done    = (state_reg == WAIT_LOAD) && bus.dmem_rvalid;

    always_comb begin
        nonload_data = 32'd0;
        case (bus.wb_sel)
            SEL_ALU: nonload_data = bus.alu_result;
            SEL_PC4: nonload_data = bus.pc_plus4;
            default: nonload_data = 32'd0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign rdata_byte[gi] = bus.dmem_rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = rdata_byte[off_reg];
    assign sel_half = off_reg[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];

    always_comb begin
        load_data = bus.dmem_rdata;
        case (funct3_reg)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_data = {24'd0, sel_byte};
            3'b101:  load_data = {16'd0, sel_half};
            default: load_data = bus.dmem_rdata;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        we_next       = we_reg;
        rd_next       = rd_reg;
        funct3_next   = funct3_reg;
        off_next      = off_reg;
        rf_we_next    = 1'b0;
        rf_waddr_next = rf_waddr_reg;
        rf_wdata_next = rf_wdata_reg;

        case (state_reg)
            IDLE: begin
                // Responses arriving here (stray or same-cycle-as-accept) are dropped.
                if (accept) begin
                    sel_next    = bus.wb_sel;
                    we_next     = bus.reg_we;
                    rd_next     = bus.rd;
                    funct3_next = bus.funct3;
                    off_next    = bus.alu_result[1:0];
                    if (load_accept) begin
                        state_next = WAIT_LOAD;
                    end else begin
                        rf_we_next    = write_gate(bus.reg_we, bus.rd, bus.wb_sel);
                        rf_waddr_next = bus.rd;
                        rf_wdata_next = nonload_data;
                    end
                end
            end
            WAIT_LOAD: begin
                if (bus.dmem_rvalid) begin
                    state_next    = IDLE;
                    rf_we_next    = write_gate(we_reg, rd_reg, sel_reg);
                    rf_waddr_next = rd_reg;
                    rf_wdata_next = load_data;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            sel_reg      <= SEL_LOAD;
            we_reg       <= 1'b0;
            rd_reg       <= 5'd0;
            funct3_reg   <= 3'd0;
            off_reg      <= 2'd0;
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= 5'd0;
            rf_wdata_reg <= 32'd0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            we_reg       <= we_next;
            rd_reg       <= rd_next;
            funct3_reg   <= funct3_next;
            off_reg      <= off_next;
            rf_we_reg    <= rf_we_next;
            rf_waddr_reg <= rf_waddr_next;
            rf_wdata_reg <= rf_wdata_next;
        end
    end

    assign bus.rf_we    = rf_we_reg;
    assign bus.rf_waddr = rf_waddr_reg;
    assign bus.rf_wdata = rf_wdata_reg;

`ifdef WB_INSTRET_EN
    logic        retire;
    logic [63:0] instret_reg;

    // Every non-load accept and every load completion retires, write gated or not.
    assign retire = (accept && !load_accept) || load_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_reg <= 64'd0;
        end else if (retire) begin
            instret_reg <= instret_reg + 64'd1;
        end
    end

    assign bus.instret = instret_reg;
`else
    assign bus.instret = 64'd0;
`endif

endmodule
